imem_dmem_port_arbiter: RTL
===========================

Name: imem_dmem_port_arbiter

Overview:
- Shares the single-port unified 1024x32 instruction/data memory between two requesters: the fetch stage (IF port, read-only) and the data-memory stage (D port, load/store).
- Sequences each access: arbitrate, issue, wait the fixed memory read latency, return data.
- Enforces a starvation bound on fetch and freezes new grants while the pipeline is halted.

Parameters:
- AW, 10, word-address width (1024 words).
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata (legal range 1..7).
- STARVE_MAX, 4, maximum consecutive D grants while if_req is pending before IF is forced.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- halt  in  1  pipeline halted; blocks new grants.
- if_req  in  1  fetch read request.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  one-cycle grant pulse to fetch.
- if_rvalid  out  1  one-cycle fetch data-valid pulse.
- if_rdata  out  DW  fetched word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data word address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  one-cycle grant pulse to data port.
- d_done  out  1  one-cycle pulse: load data valid, or store committed.
- d_rdata  out  DW  loaded word.
- mem_en  out  1  memory access strobe (one cycle per access).
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered. Reset (rst_n=0, asynchronous) clears every output to 0, the state to IDLE, the latency counter to 0 and starve_cnt to 0. An in-flight read is discarded and produces no rvalid/done.
- State machine:
  - IDLE -> ISSUE when any req and !halt.
  - ISSUE -> DONE on a store.
  - ISSUE -> WAIT on a load or fetch.
  - WAIT -> DONE after MEM_LAT cycles.
  - DONE -> IDLE.
- Arbitration is evaluated in IDLE only.
  - If if_req && starve_cnt==STARVE_MAX: grant IF.
  - Else if d_req: grant D (data port has priority; it is the older instruction).
  - Else if if_req: grant IF.
- Grant cycle = ISSUE:
  - the selected gnt pulses;
  - mem_en=1, with mem_addr/mem_we/mem_wdata from the winner (mem_we=0 for IF);
  - the winner's request fields are latched internally.
- Requesters hold req/addr/we/wdata stable until gnt and may drop req in the gnt cycle or later.
- Latency:
  - Read: req sampled at cycle 0, gnt and mem_en at cycle 1, mem_rdata captured at cycle 1+MEM_LAT, rvalid/done plus rdata at cycle 2+MEM_LAT.
  - Store: gnt at cycle 1, d_done at cycle 2.
  - The next grant is possible in the cycle after DONE (IDLE re-arbitrates).
- Response data: if_rdata/d_rdata hold their last value until the next response of that port; only the serviced port's rdata updates.
- Starvation counter (saturating at STARVE_MAX):
  - increments on each D grant while if_req=1;
  - clears on any IF grant;
  - clears on any grant made while if_req=0.
- halt:
  - sampled in IDLE only; halt=1 with a pending req gives no grant (halt wins a same-cycle tie);
  - an access already past IDLE completes normally;
  - grants resume the cycle after halt falls.
- Never more than one access in flight. if_gnt and d_gnt are never simultaneous, and neither are if_rvalid and d_done.
- Address width is fixed at AW, so no range check is needed; addresses wrap naturally.

Decomposition:
- Shared package mips32_mem_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - the port-select encoding (SEL_IF=0, SEL_D=1);
  - defaults AW=10, DW=32.
- One natural sub-module: arb_prio_starve. It is combinational priority select plus the saturating starve_cnt register, and outputs sel and grant_valid. FSM and latency counter stay in the top.

Test Plan:
- MEM_LAT=1, if_req=1, if_addr=0x005, memory word 5=0x1234_5678, d_req=0 -> if_gnt at cycle 1, mem_en/mem_addr=0x005 at cycle 1, if_rvalid with if_rdata=0x1234_5678 at cycle 3, busy=1 during cycles 1..3.
- Store: d_req=1, d_we=1, d_addr=0x3FF, d_wdata=0xDEAD_BEEF -> d_gnt and mem_en/mem_we=1 at cycle 1, d_done at cycle 2; a following load of 0x3FF returns 0xDEAD_BEEF.
- if_req and d_req both held continuously with STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; gnts never overlap.
- halt=1 asserted in the same cycle as d_req=1 -> no gnt, busy=0. Release halt -> d_gnt on the next cycle. halt raised during WAIT -> d_done still delivered.
- MEM_LAT=3 load -> d_done exactly 5 cycles after req sample. rst_n pulsed low during WAIT -> all outputs 0 immediately, no d_done. After release, a new request is serviced normally.

Source files
------------

// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter.
package mips32_mem_pkg;

    localparam int AW_DEF         = 10;
    localparam int DW_DEF         = 32;
    localparam int MEM_LAT_DEF    = 1;
    localparam int STARVE_MAX_DEF = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_D  = 1'b1;

    typedef struct packed {
        logic sel;
        logic we;
    } req_tag_t;

    // Last value the latency counter reaches in WAIT before the read data is valid.
    function automatic logic [2:0] lat_last(input int lat);
        return 3'(lat - 1);
    endfunction

endpackage

// File: rtl/arb_prio_starve.sv
// Priority select between fetch and data requesters with a saturating
// starvation counter that forces a fetch grant after STARVE_MAX data grants.
module arb_prio_starve
    import mips32_mem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic sel,
    output logic grant_valid
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_r;
    logic          force_if_s;

    // Fetch is forced once it has waited out STARVE_MAX data grants; otherwise data wins.
    always_comb begin
        force_if_s = if_req && (starve_cnt_r == CNT_MAX);
        if (force_if_s) begin
            sel = SEL_IF;
        end else if (d_req) begin
            sel = SEL_D;
        end else begin
            sel = SEL_IF;
        end
        grant_valid = arb_en && (if_req || d_req);
    end

    // Starvation counter: counts data grants that bypassed a pending fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {CW{1'b0}};
        end else if (grant_valid) begin
            if ((sel == SEL_IF) || !if_req) begin
                starve_cnt_r <= {CW{1'b0}};
            end else if (starve_cnt_r != CNT_MAX) begin
                starve_cnt_r <= starve_cnt_r + CW'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Shares the single-port unified memory between the fetch (IF) and data (D)
// stages: arbitrate, issue, wait the fixed read latency, return the response.
module imem_dmem_port_arbiter
    import mips32_mem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          halt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [2:0] LAT_LAST = lat_last(MEM_LAT);

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [2:0]    lat_cnt_r;
    req_tag_t      tag_r;
    logic          arb_en_s;
    logic          sel_s;
    logic          grant_valid_s;
    logic          win_we_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_wdata_s;
    logic          rsp_last_s;

    arb_prio_starve #(
        .STARVE_MAX(STARVE_MAX)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .arb_en     (arb_en_s),
        .if_req     (if_req),
        .d_req      (d_req),
        .sel        (sel_s),
        .grant_valid(grant_valid_s)
    );

    // Winner's request fields and the last-WAIT-cycle strobe.
    always_comb begin
        arb_en_s   = (state_r == ST_IDLE) && !halt;
        rsp_last_s = (state_r == ST_WAIT) && (lat_cnt_r == LAT_LAST);
        if (sel_s == SEL_D) begin
            win_we_s    = d_we;
            win_addr_s  = d_addr;
            win_wdata_s = d_wdata;
        end else begin
            win_we_s    = 1'b0;
            win_addr_s  = if_addr;
            win_wdata_s = {DW{1'b0}};
        end
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (tag_r.we) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_r == LAT_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, latency counter and latched winner tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            lat_cnt_r <= 3'd0;
            tag_r     <= '{sel: SEL_IF, we: 1'b0};
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_WAIT) && (lat_cnt_r != LAT_LAST)) begin
                lat_cnt_r <= lat_cnt_r + 3'd1;
            end else begin
                lat_cnt_r <= 3'd0;
            end
            if (grant_valid_s) begin
                tag_r <= '{sel: sel_s, we: win_we_s};
            end else begin
                tag_r <= tag_r;
            end
        end
    end

    // Registered grant, memory strobe and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {DW{1'b0}};
            if_rvalid <= 1'b0;
            if_rdata  <= {DW{1'b0}};
            d_done    <= 1'b0;
            d_rdata   <= {DW{1'b0}};
            busy      <= 1'b0;
        end else begin
            if_gnt <= grant_valid_s && (sel_s == SEL_IF);
            d_gnt  <= grant_valid_s && (sel_s == SEL_D);
            mem_en <= grant_valid_s;
            mem_we <= grant_valid_s && win_we_s;
            if (grant_valid_s) begin
                mem_addr  <= win_addr_s;
                mem_wdata <= win_wdata_s;
            end else begin
                mem_addr  <= mem_addr;
                mem_wdata <= mem_wdata;
            end
            // Stores complete straight out of ISSUE; reads complete at the end of WAIT.
            if_rvalid <= rsp_last_s && (tag_r.sel == SEL_IF);
            d_done    <= (rsp_last_s && (tag_r.sel == SEL_D)) ||
                         ((state_r == ST_ISSUE) && tag_r.we);
            if (rsp_last_s && (tag_r.sel == SEL_IF)) begin
                if_rdata <= mem_rdata;
            end else begin
                if_rdata <= if_rdata;
            end
            if (rsp_last_s && (tag_r.sel == SEL_D)) begin
                d_rdata <= mem_rdata;
            end else begin
                d_rdata <= d_rdata;
            end
            busy <= (state_nxt_s != ST_IDLE);
        end
    end

endmodule
